ddr3_mcb_req_ctl: RTL and testbench
===================================

DDR3_MCB_REQ_CTL -- requirements
Module: ddr3_mcb_req_ctl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- BANK_W, 3, bank address width.
- ROW_W, 14, row address width.
- COL_W, 10, column address width.
REQ-002 Ports, one per line: name, direction, width, meaning.
- ddr3_mcb_clk, in, 1, single clock; all state on its rising edge.
- ddr3_mcb_rst, in, 1, asynchronous active-high reset.
- req_valid, in, 1, front-end request present.
- req_wr_n, in, 1, request direction; 0 = write, 1 = read.
- req_addr, in, BANK_W+ROW_W+COL_W, request address, packed as {bank, row, col}.
- req_ready, out, 1, request accepted when high together with req_valid.
- ddr3_mcb_busy, in, 1, command back-end busy.
- c_act, in, 1, back-end issuing ACTIVATE to the current bank.
- c_prec, in, 1, back-end issuing PRECHARGE to the current bank.
- c_prea, in, 1, back-end issuing PRECHARGE ALL.
- c_ref, in, 1, back-end issuing REFRESH.
- c_rd, in, 1, back-end issuing READ.
- c_wr, in, 1, back-end issuing WRITE.
- ddr3_mcb_bb, out, 1, one-cycle command-begin strobe to the back-end.
- ddr3_mcb_wr_n, out, 1, latched request direction.
- row_hit, out, 1, target bank is open on the target row.
- row_miss, out, 1, target bank is open on a different row.
- row_empty, out, 1, target bank is closed.
- mcb_bank, out, BANK_W, latched bank.
- mcb_row, out, ROW_W, latched row.
- mcb_col, out, COL_W, latched column.
- hit_cnt, out, 16, saturating count of row-hit issues.

Function
REQ-003 The FSM SHALL have four states: IDLE, HOLD, ISSUE and WAIT.
REQ-004 req_ready SHALL be high only in IDLE.
REQ-005 On req_valid & req_ready, the block SHALL latch req_wr_n and req_addr into ddr3_mcb_wr_n and mcb_bank/row/col, and move IDLE->HOLD.
REQ-006 In HOLD with ddr3_mcb_busy=0, the block SHALL move to ISSUE and register row_hit/row_miss/row_empty from the bank table in that same cycle.
REQ-007 In HOLD with ddr3_mcb_busy=1, the block SHALL stay in HOLD indefinitely.
REQ-008 ddr3_mcb_bb SHALL be high for exactly the one ISSUE cycle; ISSUE->WAIT is unconditional.
REQ-009 In WAIT, the block SHALL return to IDLE on the cycle after c_rd|c_wr is sampled high.
REQ-010 Minimum latency SHALL be: accept at cycle T, bb at T+2, req_ready high again at T+4 if c_rd/c_wr arrives at T+3.
REQ-011 Exactly one of row_hit/row_miss/row_empty SHALL be high from ISSUE until the return to IDLE; all three SHALL be 0 in IDLE and HOLD.
REQ-012 Latched address, direction and row-status outputs SHALL stay stable from HOLD until the return to IDLE.
REQ-013 The bank table SHALL hold 2^BANK_W entries of {open, row}.
REQ-014 c_act SHALL set open[mcb_bank]=1 and row[mcb_bank]=mcb_row.
REQ-015 c_prec SHALL clear open[mcb_bank].
REQ-016 c_prea or c_ref SHALL clear every open bit.
REQ-017 Bank-table update priority within one cycle SHALL be: clear-all first, then c_prec, then c_act (c_act wins).
REQ-018 A table update in the same cycle as HOLD->ISSUE SHALL NOT affect the classification; classification uses the pre-update table.
REQ-019 Row status SHALL be: row_hit = open & (row == mcb_row); row_miss = open & (row != mcb_row); row_empty = ~open.
REQ-020 hit_cnt SHALL increment on each ISSUE cycle with row_hit=1 and saturate at 16'hFFFF.
REQ-021 c_rd/c_wr outside WAIT SHALL be ignored by the FSM.
REQ-022 c_act/c_prec/c_prea/c_ref SHALL update the table in any state.

Reset
REQ-023 While ddr3_mcb_rst=1, the block SHALL force state IDLE, req_ready=1, and ddr3_mcb_bb, row_hit, row_miss, row_empty, mcb_bank, mcb_row, mcb_col = 0.
REQ-024 While ddr3_mcb_rst=1, the block SHALL force ddr3_mcb_wr_n=1, all open bits = 0, all table rows = 0 and hit_cnt=0.
REQ-025 Reset asserted mid-transaction SHALL abandon the request immediately with no further bb pulse.

Verification
REQ-026 After reset, read bank 2 row 0x0123 with busy=0 -> bb at T+2, row_empty=1, wr_n=1; pulse c_act then c_rd -> IDLE.
REQ-027 Repeat bank 2 row 0x0123 as a write -> row_hit=1, ddr3_mcb_wr_n=0, hit_cnt=1.
REQ-028 Bank 2 row 0x0456 -> row_miss=1; c_prec, c_act, c_wr -> table row[2]=0x0456.
REQ-029 busy held high for 10 cycles in HOLD -> no bb, outputs stable; bb in the cycle after busy drops.
REQ-030 c_prea with c_act in the same cycle on bank 5 -> only bank 5 open; c_ref -> all banks empty on the next request.
REQ-031 Reset asserted during WAIT -> all outputs at reset values next cycle; hit_cnt forced to 0xFFFF by preload stays at 0xFFFF after a further hit.

Source files
------------

// File: rtl/ddr3_mcb_req_ctl.sv
// rtl/ddr3_mcb_req_ctl.sv - DDR3 front-end request controller with per-bank open-row tracking
//
// Accepts one front-end request at a time, latches it, waits for the command
// back-end to be free, classifies the target bank against the open-row table
// and strobes ddr3_mcb_bb for one cycle. It then waits for the back-end's
// READ/WRITE before taking the next request.
//
// Ports:
//   ddr3_mcb_clk, ddr3_mcb_rst      clock, asynchronous active-high reset
//   req_valid/req_ready             front-end handshake
//   req_wr_n, req_addr              request direction (0 = write), {bank,row,col}
//   ddr3_mcb_busy                   back-end busy; holds the request in HOLD
//   c_act/c_prec/c_prea/c_ref       back-end bank commands, update the table in any state
//   c_rd/c_wr                       back-end column command; ends a request in WAIT
//   ddr3_mcb_bb                     one-cycle command-begin strobe
//   ddr3_mcb_wr_n, mcb_bank/row/col latched request
//   row_hit/row_miss/row_empty      registered classification, valid ISSUE..WAIT
//   hit_cnt                         saturating count of row-hit issues
module ddr3_mcb_req_ctl #(
    parameter int BANK_W = 3,
    parameter int ROW_W  = 14,
    parameter int COL_W  = 10
) (
    input  logic                          ddr3_mcb_clk,
    input  logic                          ddr3_mcb_rst,
    input  logic                          req_valid,
    input  logic                          req_wr_n,
    input  logic [BANK_W+ROW_W+COL_W-1:0] req_addr,
    output logic                          req_ready,
    input  logic                          ddr3_mcb_busy,
    input  logic                          c_act,
    input  logic                          c_prec,
    input  logic                          c_prea,
    input  logic                          c_ref,
    input  logic                          c_rd,
    input  logic                          c_wr,
    output logic                          ddr3_mcb_bb,
    output logic                          ddr3_mcb_wr_n,
    output logic                          row_hit,
    output logic                          row_miss,
    output logic                          row_empty,
    output logic [BANK_W-1:0]             mcb_bank,
    output logic [ROW_W-1:0]              mcb_row,
    output logic [COL_W-1:0]              mcb_col,
    output logic [15:0]                   hit_cnt
);

    localparam int NBANK = 1 << BANK_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HOLD  = 2'd1,
        S_ISSUE = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_req_ready;
    logic               r_bb;
    logic               r_wr_n;
    logic               r_row_hit;
    logic               r_row_miss;
    logic               r_row_empty;
    logic [BANK_W-1:0]  r_bank;
    logic [ROW_W-1:0]   r_row;
    logic [COL_W-1:0]   r_col;
    logic [15:0]        r_hit_cnt;

    logic [NBANK-1:0]   r_open;
    logic [ROW_W-1:0]   r_row_tab [NBANK];

    logic [NBANK-1:0]   w_open_nxt;
    logic               w_tab_open;
    logic               w_tab_same;

    // Classification reads the registered table, so a command landing in the
    // same cycle as HOLD->ISSUE only takes effect for later requests.
    assign w_tab_open = r_open[r_bank];
    assign w_tab_same = (r_row_tab[r_bank] == r_row);

    // Later assignments override earlier ones: clear-all, then PRECHARGE, then ACTIVATE.
    always_comb begin
        w_open_nxt = r_open;
        if (c_prea || c_ref) begin
            w_open_nxt = '0;
        end
        if (c_prec) begin
            w_open_nxt[r_bank] = 1'b0;
        end
        if (c_act) begin
            w_open_nxt[r_bank] = 1'b1;
        end
    end

    always_ff @(posedge ddr3_mcb_clk or posedge ddr3_mcb_rst) begin
        if (ddr3_mcb_rst) begin
            r_open <= '0;
            for (int i = 0; i < NBANK; i++) begin
                r_row_tab[i] <= '0;
            end
        end else begin
            r_open <= w_open_nxt;
            if (c_act) begin
                r_row_tab[r_bank] <= r_row;
            end
        end
    end

    always_ff @(posedge ddr3_mcb_clk or posedge ddr3_mcb_rst) begin
        if (ddr3_mcb_rst) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_bb        <= 1'b0;
            r_wr_n      <= 1'b1;
            r_row_hit   <= 1'b0;
            r_row_miss  <= 1'b0;
            r_row_empty <= 1'b0;
            r_bank      <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_hit_cnt   <= '0;
        end else begin
            r_bb <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_wr_n      <= req_wr_n;
                        {r_bank, r_row, r_col} <= req_addr;
                        r_req_ready <= 1'b0;
                        r_state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!ddr3_mcb_busy) begin
                        r_bb        <= 1'b1;
                        r_row_hit   <= w_tab_open & w_tab_same;
                        r_row_miss  <= w_tab_open & ~w_tab_same;
                        r_row_empty <= ~w_tab_open;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_row_hit && (r_hit_cnt != 16'hFFFF)) begin
                        r_hit_cnt <= r_hit_cnt + 16'd1;
                    end
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (c_rd || c_wr) begin
                        r_row_hit   <= 1'b0;
                        r_row_miss  <= 1'b0;
                        r_row_empty <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign ddr3_mcb_bb   = r_bb;
    assign ddr3_mcb_wr_n = r_wr_n;
    assign row_hit       = r_row_hit;
    assign row_miss      = r_row_miss;
    assign row_empty     = r_row_empty;
    assign mcb_bank      = r_bank;
    assign mcb_row       = r_row;
    assign mcb_col       = r_col;
    assign hit_cnt       = r_hit_cnt;

endmodule

// File: tb/tb_ddr3_mcb_req_ctl.sv
// tb/tb_ddr3_mcb_req_ctl.sv - scoreboard bench for ddr3_mcb_req_ctl
module tb_ddr3_mcb_req_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_wr_n;
    logic [26:0] req_addr;
    logic        req_ready;
    logic        busy;
    logic        c_act, c_prec, c_prea, c_ref, c_rd, c_wr;
    logic        bb;
    logic        wr_n;
    logic        row_hit, row_miss, row_empty;
    logic [2:0]  mcb_bank;
    logic [13:0] mcb_row;
    logic [9:0]  mcb_col;
    logic [15:0] hit_cnt;

    always #5 clk = ~clk;

    ddr3_mcb_req_ctl #(.BANK_W(3), .ROW_W(14), .COL_W(10)) dut (
        .ddr3_mcb_clk (clk),
        .ddr3_mcb_rst (rst),
        .req_valid    (req_valid),
        .req_wr_n     (req_wr_n),
        .req_addr     (req_addr),
        .req_ready    (req_ready),
        .ddr3_mcb_busy(busy),
        .c_act        (c_act),
        .c_prec       (c_prec),
        .c_prea       (c_prea),
        .c_ref        (c_ref),
        .c_rd         (c_rd),
        .c_wr         (c_wr),
        .ddr3_mcb_bb  (bb),
        .ddr3_mcb_wr_n(wr_n),
        .row_hit      (row_hit),
        .row_miss     (row_miss),
        .row_empty    (row_empty),
        .mcb_bank     (mcb_bank),
        .mcb_row      (mcb_row),
        .mcb_col      (mcb_col),
        .hit_cnt      (hit_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Status encoding used by the bench: {hit, miss, empty}
    localparam logic [2:0] ST_EMPTY = 3'b001;
    localparam logic [2:0] ST_MISS  = 3'b010;
    localparam logic [2:0] ST_HIT   = 3'b100;

    typedef struct {
        logic [2:0]  b;
        logic [13:0] r;
        logic [9:0]  c;
        logic        wn;
        logic [2:0]  st;
    } exp_t;

    exp_t sb[$];

    // Reference model: what the memory banks look like from the outside.
    bit          m_open [8];
    logic [13:0] m_row  [8];
    int          m_hits;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_open[i] = 0;
            m_row[i]  = '0;
        end
        m_hits = 0;
    endfunction

    function automatic void model_cmd(input bit clr, input bit prec, input bit act,
                                      input logic [2:0] b, input logic [13:0] r);
        if (clr) for (int i = 0; i < 8; i++) m_open[i] = 0;
        if (prec) m_open[b] = 0;
        if (act) begin
            m_open[b] = 1;
            m_row[b]  = r;
        end
    endfunction

    function automatic logic [2:0] model_status(input logic [2:0] b, input logic [13:0] r);
        if (!m_open[b]) return ST_EMPTY;
        return (m_row[b] == r) ? ST_HIT : ST_MISS;
    endfunction

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_bb"}, {31'd0, bb}, 32'd0);
        chk({tag, "_wr_n"}, {31'd0, wr_n}, 32'd1);
        chk({tag, "_status"}, {29'd0, row_hit, row_miss, row_empty}, 32'd0);
        chk({tag, "_addr"}, {5'd0, mcb_bank, mcb_row, mcb_col}, 32'd0);
        chk({tag, "_hit_cnt"}, {16'd0, hit_cnt}, 32'd0);
    endtask

    // Monitor: every command-begin strobe must match the oldest outstanding request.
    logic prev_bb = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_bb = 1'b0;
        end else begin
            if (bb) begin
                if (prev_bb) begin
                    checks++;
                    failures++;
                    $display("FAIL bb_width: bb high two cycles in a row at %0t", $time);
                end else if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL bb_spurious: bb with no outstanding request at %0t", $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("mon_addr", {5'd0, mcb_bank, mcb_row, mcb_col}, {5'd0, e.b, e.r, e.c});
                    chk("mon_wr_n", {31'd0, wr_n}, {31'd0, e.wn});
                    chk("mon_status", {29'd0, row_hit, row_miss, row_empty}, {29'd0, e.st});
                end
            end
            prev_bb = bb;
        end
    end

    // One full request. All driving happens on falling edges.
    task automatic do_req(input logic [2:0] b, input logic [13:0] r, input logic [9:0] c,
                          input logic wn, input int nb,
                          input bit op_clr, input bit op_prec, input bit op_act,
                          input bit hold_act, input bit use_wr, input bit abort);
        exp_t e;
        int   t;
        bit   ops;
        t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_wr_n  = wn;
        req_addr  = {b, r, c};
        @(posedge clk);
        @(negedge clk);
        // HOLD
        req_valid = 1'b0;
        req_wr_n  = ~wn;
        req_addr  = 27'($urandom);
        chk("hold_ready", {31'd0, req_ready}, 32'd0);
        chk("hold_status", {29'd0, row_hit, row_miss, row_empty}, 32'd0);
        chk("hold_latch", {4'd0, mcb_bank, mcb_row, mcb_col, wr_n}, {4'd0, b, r, c, wn});
        e.b = b; e.r = r; e.c = c; e.wn = wn;
        e.st = model_status(b, r);
        if (e.st == ST_HIT && m_hits < 16'hFFFF) m_hits++;
        sb.push_back(e);
        busy = (nb > 0);
        for (int i = 0; i < nb; i++) begin
            c_rd = (i == 0);
            @(negedge clk);
            c_rd = 1'b0;
            chk("busy_bb", {31'd0, bb}, 32'd0);
            chk("busy_stable", {4'd0, mcb_bank, mcb_row, mcb_col, wr_n}, {4'd0, b, r, c, wn});
            chk("busy_status", {29'd0, row_hit, row_miss, row_empty}, 32'd0);
        end
        busy = 1'b0;
        if (hold_act) begin
            c_act = 1'b1;
            model_cmd(0, 0, 1, b, r);
        end
        @(negedge clk);
        // ISSUE
        c_act = 1'b0;
        chk("issue_bb", {31'd0, bb}, 32'd1);
        @(negedge clk);
        // WAIT
        chk("wait_bb", {31'd0, bb}, 32'd0);
        chk("wait_status", {29'd0, row_hit, row_miss, row_empty}, {29'd0, e.st});
        chk("wait_hit_cnt", {16'd0, hit_cnt}, m_hits);
        if (abort) begin
            rst = 1'b1;
            #1;
            chk_reset_outs("abort");
            @(negedge clk);
            rst = 1'b0;
            model_reset();
            return;
        end
        ops = op_clr | op_prec | op_act;
        if (ops) begin
            if (op_clr) begin
                if ($urandom_range(0, 1) == 0) c_prea = 1'b1; else c_ref = 1'b1;
            end
            c_prec = op_prec;
            c_act  = op_act;
            model_cmd(op_clr, op_prec, op_act, b, r);
            @(negedge clk);
            c_prea = 1'b0; c_ref = 1'b0; c_prec = 1'b0; c_act = 1'b0;
            chk("wait_hold", {31'd0, req_ready}, 32'd0);
        end
        if (use_wr) c_wr = 1'b1; else c_rd = 1'b1;
        @(negedge clk);
        c_wr = 1'b0;
        c_rd = 1'b0;
        chk("done_ready", {31'd0, req_ready}, 32'd1);
        chk("done_status", {29'd0, row_hit, row_miss, row_empty}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_wr_n = 1'b1; req_addr = '0; busy = 1'b0;
        c_act = 0; c_prec = 0; c_prea = 0; c_ref = 0; c_rd = 0; c_wr = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outs("post_reset");

        // bank 2 row 0x123: empty read, then activate
        do_req(3'd2, 14'h0123, 10'h010, 1'b1, 0, 0, 0, 1, 0, 0, 0);
        // same row as write: hit
        do_req(3'd2, 14'h0123, 10'h020, 1'b0, 0, 0, 0, 0, 0, 1, 0);
        chk("hit_cnt_one", {16'd0, hit_cnt}, 32'd1);
        // different row: miss, precharge + activate, then hit on new row
        do_req(3'd2, 14'h0456, 10'h005, 1'b1, 0, 0, 1, 1, 0, 1, 0);
        do_req(3'd2, 14'h0456, 10'h006, 1'b1, 0, 0, 0, 0, 0, 0, 0);
        // long busy stall with a stray c_rd in HOLD
        do_req(3'd3, 14'h0077, 10'h003, 1'b0, 10, 0, 0, 0, 0, 0, 0);
        // activate landing on HOLD->ISSUE must not change this classification
        do_req(3'd4, 14'h0010, 10'h000, 1'b1, 0, 0, 0, 0, 1, 0, 0);
        do_req(3'd4, 14'h0010, 10'h001, 1'b1, 0, 0, 0, 0, 0, 0, 0);
        // precharge-all together with activate on bank 5
        do_req(3'd5, 14'h0055, 10'h002, 1'b1, 0, 1, 0, 1, 0, 0, 0);
        do_req(3'd2, 14'h0456, 10'h007, 1'b1, 0, 0, 0, 0, 0, 0, 0);
        do_req(3'd4, 14'h0010, 10'h008, 1'b0, 0, 0, 0, 0, 0, 1, 0);
        do_req(3'd5, 14'h0055, 10'h009, 1'b1, 0, 1, 0, 0, 0, 0, 0);
        do_req(3'd5, 14'h0055, 10'h00A, 1'b1, 0, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            do_req(3'($urandom_range(0, 7)), 14'(14'h100 + $urandom_range(0, 2)),
                   10'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? 2 : 0,
                   $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                   1'($urandom), 0);
        end

        // reset during WAIT, then the table must be empty again
        do_req(3'd1, 14'h0009, 10'h011, 1'b0, 0, 0, 0, 0, 0, 0, 1);
        repeat (3) begin
            @(negedge clk);
            chk("post_abort_bb", {31'd0, bb}, 32'd0);
        end
        chk_reset_outs("post_abort");
        do_req(3'd1, 14'h0009, 10'h012, 1'b1, 0, 0, 0, 1, 0, 0, 0);

        // saturation of hit_cnt
        force dut.r_hit_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_hit_cnt;
        m_hits = 16'hFFFF;
        do_req(3'd1, 14'h0009, 10'h013, 1'b1, 0, 0, 0, 0, 0, 0, 0);
        chk("hit_cnt_sat", {16'd0, hit_cnt}, 32'h0000FFFF);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
